// File: rtl/bus_demux4_if.sv
// Request/target bundle for bus_demux4: one initiator-side request channel and a
// shared target channel with one-hot per-target valid/ready.
interface bus_demux4_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [WIDTH-1:0]  in_wdata;
    logic              in_we;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [WIDTH-1:0]  out_wdata;
    logic              out_we;
    logic              err;
    logic [1:0]        err_sel;

    modport slave (
        input  in_valid, in_addr, in_wdata, in_we, out_ready,
        output in_ready, out_valid, out_addr, out_wdata, out_we, err, err_sel
    );

    modport master (
        output in_valid, in_addr, in_wdata, in_we, out_ready,
        input  in_ready, out_valid, out_addr, out_wdata, out_we, err, err_sel
    );
endinterface

// File: rtl/bus_demux4.sv
// One-deep registered 1-to-4 request demux: routes a held request to the target picked by
// two address bits, with a wait-cycle timeout that drops the request and flags err.
module bus_demux4 #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned SEL_LSB = 28,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    bus_demux4_if.slave bus
);
    typedef enum logic {StIdle, StHold} state_e;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e            r_state;
    state_e            w_state_next;
    logic [1:0]        r_sel;
    logic [ADDR_W-1:0] r_addr;
    logic [WIDTH-1:0]  r_wdata;
    logic              r_we;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_next;
    logic              r_err;
    logic [1:0]        r_err_sel;

    logic              w_in_ready;
    logic              w_load;
    logic              w_drop;
    logic              w_sel_ready;
    logic [3:0]        w_out_valid;
    logic [1:0]        w_in_sel;

    assign w_in_sel    = bus.in_addr[SEL_LSB+1:SEL_LSB];
    // Only the ready of the currently selected target matters.
    assign w_sel_ready = bus.out_ready[r_sel];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        w_drop       = 1'b0;
        w_in_ready   = 1'b0;
        w_out_valid  = 4'b0000;
        case (r_state)
            StIdle: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_load       = 1'b1;
                    w_cnt_next   = 8'd0;
                    w_state_next = StHold;
                end
            end
            StHold: begin
                w_out_valid = 4'b0001 << r_sel;
                // Pass-through ready keeps one request per cycle when the target never stalls.
                w_in_ready  = w_sel_ready;
                if (w_sel_ready) begin
                    w_cnt_next = 8'd0;
                    if (bus.in_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = StIdle;
                    end
                end else if (r_cnt == TimeoutCnt) begin
                    w_drop       = 1'b1;
                    w_cnt_next   = 8'd0;
                    w_state_next = StIdle;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
        if (reset) begin
            w_in_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_sel     <= 2'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_cnt     <= 8'd0;
            r_err     <= 1'b0;
            r_err_sel <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_drop;
            if (w_load) begin
                r_sel   <= w_in_sel;
                r_addr  <= bus.in_addr;
                r_wdata <= bus.in_wdata;
                r_we    <= bus.in_we;
            end
            if (w_drop) begin
                r_err_sel <= r_sel;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_addr  = r_addr;
    assign bus.out_wdata = r_wdata;
    assign bus.out_we    = r_we;
    assign bus.err       = r_err;
    assign bus.err_sel   = r_err_sel;
endmodule

// File: tb/tb_bus_demux4.sv
// Bench for bus_demux4: default-timeout instance for routing/throughput/backpressure/reset,
// and a TIMEOUT=4 instance for the drop and ready-vs-timeout race.
module tb_bus_demux4;
    localparam int unsigned W  = 32;
    localparam int unsigned AW = 32;

    typedef struct packed {
        logic [3:0]    valid;
        logic [AW-1:0] addr;
        logic [W-1:0]  wdata;
        logic          we;
    } exp_t;

    typedef struct packed {
        logic          in_valid;
        logic [AW-1:0] addr;
        logic [W-1:0]  wdata;
        logic          we;
        logic [3:0]    out_ready;
        logic [3:0]    valid;
    } stim_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb0[$];
    exp_t sb1[$];

    always #5 clk = ~clk;

    bus_demux4_if #(.WIDTH(W), .ADDR_W(AW)) bus0 ();
    bus_demux4_if #(.WIDTH(W), .ADDR_W(AW)) bus1 ();

    bus_demux4 #(.WIDTH(W), .ADDR_W(AW), .SEL_LSB(28), .TIMEOUT(255)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    bus_demux4 #(.WIDTH(W), .ADDR_W(AW), .SEL_LSB(28), .TIMEOUT(4)) u_dut_t4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus0.in_ready, bus0.out_valid, bus0.out_addr, bus0.out_wdata, bus0.out_we,
             bus0.err, bus0.err_sel} !== 73'd0) begin
            failures++;
            $display("FAIL rst_state0 got rdy=%b v=%b a=%h d=%h we=%b err=%b sel=%0d required all 0",
                     bus0.in_ready, bus0.out_valid, bus0.out_addr, bus0.out_wdata, bus0.out_we,
                     bus0.err, bus0.err_sel);
        end
        checks++;
        if ({bus1.in_ready, bus1.out_valid, bus1.out_addr, bus1.out_wdata, bus1.out_we,
             bus1.err, bus1.err_sel} !== 73'd0) begin
            failures++;
            $display("FAIL rst_state1 got rdy=%b v=%b err=%b required all 0",
                     bus1.in_ready, bus1.out_valid, bus1.err);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus0.in_ready, bus1.in_ready} !== 2'b11) begin
            failures++;
            $display("FAIL rst_release_ready got %b%b required 11", bus0.in_ready, bus1.in_ready);
        end
    endtask

    task automatic test_single();
        exp_t e;
        @(posedge clk); #1;
        bus0.in_valid  = 1'b1;
        bus0.in_addr   = 32'h2000_0010;
        bus0.in_wdata  = 32'hDEAD_BEEF;
        bus0.in_we     = 1'b1;
        bus0.out_ready = 4'hF;
        @(negedge clk);
        checks++;
        if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 4'b0000) begin
            failures++;
            $display("FAIL single_accept got rdy=%b v=%b required rdy=1 v=0000",
                     bus0.in_ready, bus0.out_valid);
        end
        if (bus0.in_valid && bus0.in_ready)
            sb0.push_back(exp_t'({4'b0100, 32'h2000_0010, 32'hDEAD_BEEF, 1'b1}));
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus0.out_valid !== 4'b0100) begin
            failures++;
            $display("FAIL single_latency got v=%b required 0100", bus0.out_valid);
        end
        if ((bus0.out_valid & bus0.out_ready) != 4'b0000) begin
            checks++;
            if (sb0.size() == 0) begin
                failures++;
                $display("FAIL single_out got v=%b required no output", bus0.out_valid);
            end else begin
                e = sb0.pop_front();
                if ({bus0.out_valid, bus0.out_addr, bus0.out_wdata, bus0.out_we} !== e) begin
                    failures++;
                    $display("FAIL single_out got v=%b a=%h d=%h we=%b required v=%b a=%h d=%h we=%b",
                             bus0.out_valid, bus0.out_addr, bus0.out_wdata, bus0.out_we,
                             e.valid, e.addr, e.wdata, e.we);
                end
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus0.out_valid !== 4'b0000 || bus0.in_ready !== 1'b1 || sb0.size() != 0) begin
            failures++;
            $display("FAIL single_idle got v=%b rdy=%b pending=%0d required v=0000 rdy=1 pending=0",
                     bus0.out_valid, bus0.in_ready, sb0.size());
        end
    endtask

    task automatic test_back_to_back();
        exp_t  e;
        stim_t tbl [5];
        tbl[0] = {1'b1, 32'h0000_0004, 32'h1111_1111, 1'b1, 4'hF, 4'b0001};
        tbl[1] = {1'b1, 32'h1000_0008, 32'h2222_2222, 1'b0, 4'hF, 4'b0010};
        tbl[2] = {1'b1, 32'h3000_000C, 32'h3333_3333, 1'b1, 4'hF, 4'b1000};
        tbl[3] = {1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'hF, 4'b0000};
        tbl[4] = {1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'hF, 4'b0000};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus0.in_valid  = tbl[i].in_valid;
            bus0.in_addr   = tbl[i].addr;
            bus0.in_wdata  = tbl[i].wdata;
            bus0.in_we     = tbl[i].we;
            bus0.out_ready = tbl[i].out_ready;
            @(negedge clk);
            if (tbl[i].in_valid) begin
                checks++;
                if (bus0.in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_in_ready row=%0d got %b required 1", i, bus0.in_ready);
                end
            end
            if ((bus0.out_valid & bus0.out_ready) != 4'b0000) begin
                checks++;
                if (sb0.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_out row=%0d got v=%b required no output", i, bus0.out_valid);
                end else begin
                    e = sb0.pop_front();
                    if ({bus0.out_valid, bus0.out_addr, bus0.out_wdata, bus0.out_we} !== e) begin
                        failures++;
                        $display("FAIL b2b_out row=%0d got v=%b a=%h d=%h we=%b required v=%b a=%h d=%h we=%b",
                                 i, bus0.out_valid, bus0.out_addr, bus0.out_wdata, bus0.out_we,
                                 e.valid, e.addr, e.wdata, e.we);
                    end
                end
            end
            if (bus0.in_valid && bus0.in_ready)
                sb0.push_back(exp_t'({tbl[i].valid, tbl[i].addr, tbl[i].wdata, tbl[i].we}));
        end
        checks++;
        if (bus0.out_valid !== 4'b0000 || sb0.size() != 0) begin
            failures++;
            $display("FAIL b2b_drain got v=%b pending=%0d required v=0000 pending=0",
                     bus0.out_valid, sb0.size());
        end
    endtask

    // Non-select address bits are noisy and only the held target's ready bit is ever offered.
    task automatic test_select_field();
        exp_t  e;
        stim_t tbl [6];
        tbl[0] = {1'b1, 32'hCFFF_FFF0, 32'hA0A0_A0A0, 1'b1, 4'b0000, 4'b0001};
        tbl[1] = {1'b1, 32'hF000_0000, 32'hB1B1_B1B1, 1'b0, 4'b0001, 4'b1000};
        tbl[2] = {1'b1, 32'h5ABC_DEF0, 32'hC2C2_C2C2, 1'b1, 4'b1000, 4'b0010};
        tbl[3] = {1'b1, 32'hA000_0001, 32'hD3D3_D3D3, 1'b0, 4'b0010, 4'b0100};
        tbl[4] = {1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'b0100, 4'b0000};
        tbl[5] = {1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'b0000, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus0.in_valid  = tbl[i].in_valid;
            bus0.in_addr   = tbl[i].addr;
            bus0.in_wdata  = tbl[i].wdata;
            bus0.in_we     = tbl[i].we;
            bus0.out_ready = tbl[i].out_ready;
            @(negedge clk);
            if (tbl[i].in_valid) begin
                checks++;
                if (bus0.in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL sel_in_ready row=%0d got %b required 1", i, bus0.in_ready);
                end
            end
            if ((bus0.out_valid & bus0.out_ready) != 4'b0000) begin
                checks++;
                if (sb0.size() == 0) begin
                    failures++;
                    $display("FAIL sel_out row=%0d got v=%b required no output", i, bus0.out_valid);
                end else begin
                    e = sb0.pop_front();
                    if ({bus0.out_valid, bus0.out_addr, bus0.out_wdata, bus0.out_we} !== e) begin
                        failures++;
                        $display("FAIL sel_out row=%0d got v=%b a=%h d=%h required v=%b a=%h d=%h",
                                 i, bus0.out_valid, bus0.out_addr, bus0.out_wdata,
                                 e.valid, e.addr, e.wdata);
                    end
                end
            end
            if (bus0.in_valid && bus0.in_ready)
                sb0.push_back(exp_t'({tbl[i].valid, tbl[i].addr, tbl[i].wdata, tbl[i].we}));
        end
        checks++;
        if (bus0.out_valid !== 4'b0000 || sb0.size() != 0) begin
            failures++;
            $display("FAIL sel_drain got v=%b pending=%0d required v=0000 pending=0",
                     bus0.out_valid, sb0.size());
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        @(posedge clk); #1;
        bus0.in_valid  = 1'b1;
        bus0.in_addr   = 32'h1000_0020;
        bus0.in_wdata  = 32'h1234_5678;
        bus0.in_we     = 1'b0;
        bus0.out_ready = 4'b1101;
        @(negedge clk);
        checks++;
        if (bus0.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_accept got rdy=%b required 1", bus0.in_ready);
        end
        if (bus0.in_valid && bus0.in_ready)
            sb0.push_back(exp_t'({4'b0010, 32'h1000_0020, 32'h1234_5678, 1'b0}));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus0.in_valid = 1'b1;
            bus0.in_addr  = 32'h0000_0000;
            bus0.in_wdata = 32'hFFFF_FFFF;
            bus0.in_we    = 1'b1;
            @(negedge clk);
            checks++;
            if ({bus0.out_valid, bus0.out_addr, bus0.out_wdata, bus0.out_we} !==
                {4'b0010, 32'h1000_0020, 32'h1234_5678, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v=%b a=%h d=%h we=%b required v=0010 a=10000020 d=12345678 we=0",
                         i, bus0.out_valid, bus0.out_addr, bus0.out_wdata, bus0.out_we);
            end
            checks++;
            if (bus0.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_in_ready cyc=%0d got %b required 0", i, bus0.in_ready);
            end
        end
        @(posedge clk); #1;
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 4'hF;
        @(negedge clk);
        checks++;
        if (bus0.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready got %b required 1", bus0.in_ready);
        end
        if ((bus0.out_valid & bus0.out_ready) != 4'b0000) begin
            checks++;
            if (sb0.size() == 0) begin
                failures++;
                $display("FAIL bp_out got v=%b required no output", bus0.out_valid);
            end else begin
                e = sb0.pop_front();
                if ({bus0.out_valid, bus0.out_addr, bus0.out_wdata, bus0.out_we} !== e) begin
                    failures++;
                    $display("FAIL bp_out got v=%b a=%h d=%h required v=%b a=%h d=%h",
                             bus0.out_valid, bus0.out_addr, bus0.out_wdata, e.valid, e.addr, e.wdata);
                end
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus0.out_valid !== 4'b0000 || sb0.size() != 0) begin
            failures++;
            $display("FAIL bp_drain got v=%b pending=%0d required v=0000 pending=0",
                     bus0.out_valid, sb0.size());
        end
    endtask

    task automatic test_timeout();
        @(posedge clk); #1;
        bus1.in_valid  = 1'b1;
        bus1.in_addr   = 32'h3000_0000;
        bus1.in_wdata  = 32'h0BAD_0BAD;
        bus1.in_we     = 1'b1;
        bus1.out_ready = 4'b0111;
        @(negedge clk);
        checks++;
        if (bus1.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL to_accept got rdy=%b required 1", bus1.in_ready);
        end
        if (bus1.in_valid && bus1.in_ready)
            sb1.push_back(exp_t'({4'b1000, 32'h3000_0000, 32'h0BAD_0BAD, 1'b1}));
        // A competing request is offered throughout, including the timeout cycle.
        for (int h = 1; h <= 5; h++) begin
            @(posedge clk); #1;
            bus1.in_valid = 1'b1;
            bus1.in_addr  = 32'h0000_0000;
            @(negedge clk);
            checks++;
            if ({bus1.out_valid, bus1.err, bus1.in_ready} !== {4'b1000, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL to_hold cyc=%0d got v=%b err=%b rdy=%b required v=1000 err=0 rdy=0",
                         h, bus1.out_valid, bus1.err, bus1.in_ready);
            end
        end
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus1.err, bus1.err_sel, bus1.out_valid, bus1.in_ready} !==
            {1'b1, 2'd3, 4'b0000, 1'b1}) begin
            failures++;
            $display("FAIL to_drop got err=%b sel=%0d v=%b rdy=%b required err=1 sel=3 v=0000 rdy=1",
                     bus1.err, bus1.err_sel, bus1.out_valid, bus1.in_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({bus1.err, bus1.err_sel, bus1.out_valid} !== {1'b0, 2'd3, 4'b0000}) begin
            failures++;
            $display("FAIL to_pulse got err=%b sel=%0d v=%b required err=0 sel=3 v=0000",
                     bus1.err, bus1.err_sel, bus1.out_valid);
        end
        sb1.delete();
    endtask

    task automatic test_race();
        exp_t e;
        @(posedge clk); #1;
        bus1.in_valid  = 1'b1;
        bus1.in_addr   = 32'h3000_0040;
        bus1.in_wdata  = 32'hCAFE_F00D;
        bus1.in_we     = 1'b0;
        bus1.out_ready = 4'b0111;
        @(negedge clk);
        if (bus1.in_valid && bus1.in_ready)
            sb1.push_back(exp_t'({4'b1000, 32'h3000_0040, 32'hCAFE_F00D, 1'b0}));
        for (int h = 1; h <= 5; h++) begin
            @(posedge clk); #1;
            bus1.in_valid  = 1'b0;
            bus1.out_ready = (h == 5) ? 4'b1111 : 4'b0111;
            @(negedge clk);
            checks++;
            if (bus1.out_valid !== 4'b1000 || bus1.err !== 1'b0) begin
                failures++;
                $display("FAIL race_hold cyc=%0d got v=%b err=%b required v=1000 err=0",
                         h, bus1.out_valid, bus1.err);
            end
            if ((bus1.out_valid & bus1.out_ready) != 4'b0000) begin
                checks++;
                if (sb1.size() == 0) begin
                    failures++;
                    $display("FAIL race_out cyc=%0d got v=%b required no output", h, bus1.out_valid);
                end else begin
                    e = sb1.pop_front();
                    if ({bus1.out_valid, bus1.out_addr, bus1.out_wdata, bus1.out_we} !== e) begin
                        failures++;
                        $display("FAIL race_out got v=%b a=%h d=%h required v=%b a=%h d=%h",
                                 bus1.out_valid, bus1.out_addr, bus1.out_wdata,
                                 e.valid, e.addr, e.wdata);
                    end
                end
            end
        end
        @(posedge clk); #1;
        bus1.out_ready = 4'b0000;
        @(negedge clk);
        checks++;
        if ({bus1.err, bus1.out_valid, bus1.in_ready} !== {1'b0, 4'b0000, 1'b1} ||
            sb1.size() != 0) begin
            failures++;
            $display("FAIL race_after got err=%b v=%b rdy=%b pending=%0d required err=0 v=0000 rdy=1 pending=0",
                     bus1.err, bus1.out_valid, bus1.in_ready, sb1.size());
        end
    endtask

    task automatic test_reset_in_hold();
        @(posedge clk); #1;
        bus0.in_valid  = 1'b1;
        bus0.in_addr   = 32'h2000_0000;
        bus0.in_wdata  = 32'h5555_AAAA;
        bus0.in_we     = 1'b1;
        bus0.out_ready = 4'b0000;
        @(negedge clk);
        if (bus0.in_valid && bus0.in_ready)
            sb0.push_back(exp_t'({4'b0100, 32'h2000_0000, 32'h5555_AAAA, 1'b1}));
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus0.out_valid !== 4'b0100) begin
            failures++;
            $display("FAIL rih_hold got v=%b required 0100", bus0.out_valid);
        end
        @(posedge clk); #1;
        reset          = 1'b1;
        bus0.out_ready = 4'hF;
        @(negedge clk);
        checks++;
        if (bus0.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rih_ready_in_reset got %b required 0", bus0.in_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({bus0.out_valid, bus0.err, bus0.in_ready} !== {4'b0000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL rih_cleared got v=%b err=%b rdy=%b required v=0000 err=0 rdy=0",
                     bus0.out_valid, bus0.err, bus0.in_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus0.out_valid, bus0.err, bus0.in_ready} !== {4'b0000, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL rih_release got v=%b err=%b rdy=%b required v=0000 err=0 rdy=1",
                     bus0.out_valid, bus0.err, bus0.in_ready);
        end
        sb0.delete();
    endtask

    initial begin
        reset          = 1'b1;
        bus0.in_valid  = 1'b0;
        bus0.in_addr   = '0;
        bus0.in_wdata  = '0;
        bus0.in_we     = 1'b0;
        bus0.out_ready = 4'b0000;
        bus1.in_valid  = 1'b0;
        bus1.in_addr   = '0;
        bus1.in_wdata  = '0;
        bus1.in_we     = 1'b0;
        bus1.out_ready = 4'b0000;
        test_reset();
        test_single();
        test_back_to_back();
        test_select_field();
        test_backpressure();
        test_timeout();
        test_race();
        test_reset_in_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_demux4.md
BUS_DEMUX4 -- requirements
Module: bus_demux4

Interface
REQ-001 Parameter WIDTH, default 32: data width of in_wdata/out_wdata.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter SEL_LSB, default 28: target select is addr[SEL_LSB+1:SEL_LSB].
REQ-004 Parameter TIMEOUT, default 255, legal range 1..255: max HOLD cycles waiting for target ready.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 in_valid  input  1  initiator request valid.
REQ-009 in_ready  output  1  block can accept a request this cycle.
REQ-010 in_addr  input  ADDR_W  request address.
REQ-011 in_wdata  input  WIDTH  request write data.
REQ-012 in_we  input  1  request write enable.
REQ-013 out_valid  output  4  one-hot per-target valid.
REQ-014 out_ready  input  4  per-target ready.
REQ-015 out_addr  output  ADDR_W  registered address, shared by all targets.
REQ-016 out_wdata  output  WIDTH  registered write data, shared.
REQ-017 out_we  output  1  registered write enable, shared.
REQ-018 err  output  1  one-cycle pulse on timeout drop.
REQ-019 err_sel  output  2  target index of the last dropped request.

Function
REQ-020 The block SHALL have two states: IDLE (no held request) and HOLD (one request held, presented to a target).
REQ-021 Handshake on either side SHALL occur only when valid and ready are both 1 on the same rising edge.
REQ-022 In IDLE, in_ready SHALL be 1 and all out_valid bits SHALL be 0.
REQ-023 On an in_valid/in_ready handshake, the block SHALL register in_addr, in_wdata and in_we, plus sel = in_addr[SEL_LSB+1:SEL_LSB], and enter HOLD.
REQ-024 In HOLD, out_valid SHALL equal 1<<sel, and out_addr/out_wdata/out_we SHALL hold the captured values unchanged until handshake or drop.
REQ-025 Latency: a request accepted on edge N SHALL show out_valid on the cycle after edge N.
REQ-026 out_ready bits other than out_ready[sel] SHALL be ignored.
REQ-027 In HOLD, in_ready SHALL equal out_ready[sel] (combinational), giving back-to-back throughput of one request per cycle.
REQ-028 Simultaneous HOLD-side handshake and new input handshake SHALL load the new request and stay in HOLD; with no new input, the block SHALL return to IDLE.
REQ-029 An 8-bit wait counter SHALL clear on entering HOLD and on every output handshake, and SHALL increment each HOLD cycle without a handshake.
REQ-030 When the wait counter equals TIMEOUT with no handshake that cycle, the block SHALL drop the request, go to IDLE, pulse err for exactly one cycle, and load err_sel with sel.
REQ-031 in_ready SHALL be 0 on the timeout cycle, so no request is accepted then.
REQ-032 If out_ready[sel] rises on the same cycle as the timeout, the handshake SHALL win: no err, counter cleared.
REQ-033 Select values 0..3 SHALL all be legal; no address outside the select field SHALL affect routing.

Reset
REQ-034 While reset is high at a rising edge: state becomes IDLE, out_valid=0, out_addr=0, out_wdata=0, out_we=0, err=0, err_sel=0, wait counter=0.
REQ-035 Reset during HOLD SHALL discard the held request without asserting err.
REQ-036 in_ready SHALL be 0 while reset is high, and 1 on the first cycle after reset.

Verification
REQ-037 Single write in_addr=0x2000_0010, wdata=0xDEAD_BEEF, we=1, out_ready=4'b1111 -> out_valid=4'b0100 one cycle after acceptance, out_wdata=0xDEAD_BEEF, then IDLE.
REQ-038 Back-to-back addr 0x0..., 0x1..., 0x3... with out_ready=4'b1111 -> out_valid sequence 0001, 0010, 1000 on consecutive cycles; in_ready stays 1.
REQ-039 Backpressure: target 1 with out_ready[1]=0 for 5 cycles, other ready bits=1 -> out_valid=0010 held stable, out_wdata unchanged, in_ready=0 until out_ready[1]=1.
REQ-040 Timeout with TIMEOUT=4 and target 3 never ready -> err pulses once on the 5th HOLD cycle, err_sel=3, out_valid=0 next cycle, in_ready=1.
REQ-041 Race with TIMEOUT=4: out_ready[3] rises on the timeout cycle -> handshake completes, err stays 0.
REQ-042 Reset asserted in HOLD -> next cycle out_valid=0, err=0, in_ready=0 while reset is high, then 1.
